anffl_tex_texel_fetch: RTL and testbench

Texel fetch stage of the TEX unit, directly downstream of coordinate denormalization. It takes a pair of integer texel indices (u, v), forms the texel's byte address from the texture descriptor, and issues a single-word read on the texture memory port. It unpacks the returned word into RGBA8888 and presents the texel to the filter stage over a valid/ready handshake. One fetch is in flight at a time.

---
 rtl/anffl_tex_pkg.sv | 26 ++
 rtl/anffl_tex_texel_unpack.sv | 43 ++++
 rtl/anffl_tex_texel_fetch.sv | 108 ++++++++++
 tb/tb_anffl_tex_texel_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/anffl_tex_pkg.sv
// Shared definitions for the TEX texel fetch path.
//   - texture format encodings
//   - fetch FSM state encoding
//   - texel size (log2 bytes) per format
package anffl_tex_pkg;

  localparam logic [1:0] FMT_RGBA8888 = 2'b00;
  localparam logic [1:0] FMT_RGB565   = 2'b01;
  localparam logic [1:0] FMT_L8       = 2'b10;
  localparam logic [1:0] FMT_RSVD     = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // log2 of the texel size in bytes; the reserved format never addresses memory
  function automatic logic [1:0] texel_shift(input logic [1:0] fmt);
    case (fmt)
      FMT_RGBA8888: texel_shift = 2'd2;
      FMT_RGB565:   texel_shift = 2'd1;
      default:      texel_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/anffl_tex_texel_unpack.sv
// Combinational expansion of one memory word into an RGBA8888 texel.
//   fmt   : texture format (anffl_tex_pkg encodings)
//   lane  : byte offset of the texel inside the 32-bit word
//   rdata : raw memory word
//   texel : R[31:24] G[23:16] B[15:8] A[7:0]
module anffl_tex_texel_unpack
  import anffl_tex_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] texel
);

  logic [15:0] half;
  logic [7:0]  lum;
  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;

  always_comb begin
    half = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    lum = rdata[7:0];
      2'd1:    lum = rdata[15:8];
      2'd2:    lum = rdata[23:16];
      default: lum = rdata[31:24];
    endcase
    r5 = half[15:11];
    g6 = half[10:5];
    b5 = half[4:0];

    case (fmt)
      // memory stores R in the lowest byte; output wants R in the highest
      FMT_RGBA8888: texel = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
      // replicate MSBs into the vacated LSBs so full-scale maps to 0xFF
      FMT_RGB565:   texel = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2], 8'hFF};
      FMT_L8:       texel = {lum, lum, lum, 8'hFF};
      default:      texel = 32'h0;
    endcase
  end

endmodule

// File: rtl/anffl_tex_texel_fetch.sv
// Texel fetch stage: turns (u, v) texel indices into a word read on the
// texture memory port, unpacks the returned word to RGBA8888 and hands it
// to the filter stage. One fetch in flight at a time.
//   in_*       : request handshake, indices, texture descriptor
//   mem_*      : single-word read port (req/gnt, then rvalid/rdata)
//   out_*      : texel handshake towards the filter stage
module anffl_tex_texel_fetch
  import anffl_tex_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_u,
  input  logic [15:0]       in_v,
  input  logic [3:0]        in_widthExp,
  input  logic [3:0]        in_heightExp,
  input  logic [1:0]        in_format,
  input  logic [ADDR_W-1:0] in_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_texel
);

  logic [1:0]  state;
  logic [1:0]  fmt;
  logic [1:0]  lane;

  logic [15:0] mask_u;
  logic [15:0] mask_v;
  logic [31:0] texel_idx;
  logic [31:0] byte_addr;
  logic [31:0] unpacked;

  // Address generation; out-of-range indices wrap via the power-of-two mask
  always_comb begin
    mask_u    = (16'd1 << in_widthExp) - 16'd1;
    mask_v    = (16'd1 << in_heightExp) - 16'd1;
    texel_idx = ({16'h0, in_v & mask_v} << in_widthExp) + {16'h0, in_u & mask_u};
    byte_addr = 32'(in_base) + (texel_idx << texel_shift(in_format));
  end

  anffl_tex_texel_unpack u_unpack (
    .fmt   (fmt),
    .lane  (lane),
    .rdata (mem_rdata),
    .texel (unpacked)
  );

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fmt       <= FMT_RGBA8888;
      lane      <= 2'd0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_texel <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            fmt <= in_format;
            if (in_format == FMT_RSVD) begin
              out_texel <= 32'h0;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              lane     <= byte_addr[1:0];
              mem_addr <= ADDR_W'({byte_addr[31:2], 2'b00});
              mem_req  <= 1'b1;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            out_texel <= unpacked;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anffl_tex_texel_fetch.sv
// Self-checking bench for anffl_tex_texel_fetch: directed cases followed by
// randomized transactions checked against an arithmetic reference model.
module tb_anffl_tex_texel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_u;
  logic [15:0] in_v;
  logic [3:0]  in_widthExp;
  logic [3:0]  in_heightExp;
  logic [1:0]  in_format;
  logic [31:0] in_base;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_texel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  anffl_tex_texel_fetch #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_u         (in_u),
    .in_v         (in_v),
    .in_widthExp  (in_widthExp),
    .in_heightExp (in_heightExp),
    .in_format    (in_format),
    .in_base      (in_base),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_texel    (out_texel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: linear texel offset times texel size in bytes
  function automatic logic [31:0] model_byte_addr(input logic [1:0] f, input logic [31:0] base,
                                                  input int we, input int he,
                                                  input int u, input int v);
    longint w, h, bytes, a;
    w = longint'(1) << we;
    h = longint'(1) << he;
    bytes = (f == 2'd0) ? 4 : (f == 2'd1) ? 2 : 1;
    a = longint'(base) + ((longint'(v) % h) * w + (longint'(u) % w)) * bytes;
    return a[31:0];
  endfunction

  function automatic logic [31:0] model_texel(input logic [1:0] f, input logic [31:0] baddr,
                                              input logic [31:0] rd);
    int off, half, r, g, b, l;
    off = int'(baddr % 4);
    case (f)
      2'd0: return {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
      2'd1: begin
        half = (off >= 2) ? int'(rd / 65536) : int'(rd % 65536);
        r = half / 2048;
        g = (half / 32) % 64;
        b = half % 32;
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4), 8'hFF};
      end
      2'd2: begin
        l = int'((rd >> (8 * off)) % 256);
        return {8'(l), 8'(l), 8'(l), 8'hFF};
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic run_txn(input string tag, input logic [1:0] f, input logic [31:0] base,
                         input int we, input int he, input int u, input int v,
                         input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                         input int out_dly);
    logic [31:0] baddr, eaddr, etex;
    baddr = model_byte_addr(f, base, we, he, u, v);
    eaddr = baddr & 32'hFFFF_FFFC;
    etex  = model_texel(f, baddr, rd);

    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_format = f; in_base = base;
    in_widthExp = 4'(we); in_heightExp = 4'(he); in_u = 16'(u); in_v = 16'(v);
    tick();
    in_valid = 1'b0;
    in_u = 16'($urandom); in_v = 16'($urandom); in_base = $urandom;
    in_format = 2'($urandom);

    if (f == 2'd3) begin
      check({tag, ".rsvd_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".rsvd_mem_req"}, 32'(mem_req), 32'd0);
    end else begin
      check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      check({tag, ".mem_addr"}, mem_addr, eaddr);
      for (int i = 0; i < gnt_dly; i++) begin
        tick();
        check({tag, ".req_hold"}, 32'(mem_req), 32'd1);
        check({tag, ".addr_hold"}, mem_addr, eaddr);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
        tick();
        check({tag, ".wait_no_valid"}, 32'(out_valid), 32'd0);
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      tick();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    end
    check({tag, ".texel"}, out_texel, etex);
    for (int i = 0; i < out_dly; i++) begin
      tick();
      check({tag, ".texel_hold"}, out_texel, etex);
      check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [1:0] f;
    int we, he;
    logic [31:0] base;

    rst_n = 1'b0; in_valid = 1'b0; in_u = '0; in_v = '0; in_widthExp = '0;
    in_heightExp = '0; in_format = '0; in_base = '0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_texel", out_texel, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Directed cases with hard-coded expectations
    run_txn("rgba", 2'd0, 32'h1000, 4, 4, 3, 2, 32'h44332211, 0, 0, 0);
    check("rgba.addr_const", model_byte_addr(2'd0, 32'h1000, 4, 4, 3, 2), 32'h108C);
    run_txn("rgb565", 2'd1, 32'h2000, 3, 3, 5, 1, 32'hF800_0000, 5, 1, 3);
    check("rgb565.tex_const", model_texel(2'd1, 32'h201A, 32'hF800_0000), 32'hFF0000FF);
    run_txn("l8", 2'd2, 32'h3003, 4, 4, 16, 0, 32'h8000_0000, 0, 2, 0);
    check("l8.tex_const", model_texel(2'd2, 32'h3003, 32'h8000_0000), 32'h808080FF);
    run_txn("rsvd", 2'd3, 32'h4000, 4, 4, 1, 1, 32'h0, 0, 0, 2);

    // Reset pulse while waiting for read data; the late rvalid must be ignored
    in_valid = 1'b1; in_format = 2'd0; in_base = 32'h5000; in_widthExp = 4'd2;
    in_heightExp = 4'd2; in_u = 16'd1; in_v = 16'd1;
    tick();
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstwait.in_ready", 32'(in_ready), 32'd1);
    check("rstwait.mem_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    check("rstwait.out_valid", 32'(out_valid), 32'd0);
    check("rstwait.idle", 32'(in_ready), 32'd1);
    check("rstwait.mem_req2", 32'(mem_req), 32'd0);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      f  = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      we = $urandom_range(0, 15);
      he = $urandom_range(0, 15);
      base = $urandom;
      if (f == 2'd0) base[1:0] = 2'b00;
      if (f == 2'd1) base[0] = 1'b0;
      run_txn($sformatf("rnd%0d", t), f, base, we, he,
              $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
